// File: rtl/fetch_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_ctrl_if
// Brief    : Hazard-control, instruction-memory and IF/ID bundle of the fetch stage.
// Revision : 1.0
// ============================================================================
interface fetch_stage_ctrl_if #(
   parameter int unsigned CNT_WIDTH = 16
);
   logic                 PCWriteEnable;
   logic                 IFIDWriteEnable;
   logic                 Branch;
   logic [31:0]          BranchTarget;
   logic [31:0]          IMemData;
   logic [31:0]          PC;
   logic [31:0]          IFIDInstruction;
   logic [31:0]          IFIDPCPlus4;
   logic                 IFIDValid;
   logic [CNT_WIDTH-1:0] StallCycles;
   logic [CNT_WIDTH-1:0] BranchFlushes;
   logic                 StallWatchdog;

   modport master (
      output PCWriteEnable, IFIDWriteEnable, Branch, BranchTarget, IMemData,
      input  PC, IFIDInstruction, IFIDPCPlus4, IFIDValid,
      input  StallCycles, BranchFlushes, StallWatchdog
   );

   modport slave (
      input  PCWriteEnable, IFIDWriteEnable, Branch, BranchTarget, IMemData,
      output PC, IFIDInstruction, IFIDPCPlus4, IFIDValid,
      output StallCycles, BranchFlushes, StallWatchdog
   );
endinterface
`default_nettype wire

// File: rtl/fetch_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage_ctrl
// Brief    : MIPS IF stage: PC, IF/ID register, stall/flush statistics, stall watchdog.
// Revision : 1.0
// ============================================================================
module fetch_stage_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned STALL_LIMIT = 8,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  wire logic         Clock,
   input  wire logic         Reset,
   fetch_stage_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } state_t;

   localparam logic [7:0]           LIMIT   = 8'(STALL_LIMIT);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t               state;
   state_t               state_next;
   logic                 active;
   logic                 stall;
   logic                 flush;
   logic [31:0]          pc;
   logic [31:0]          pc_plus4;
   logic [31:0]          ifid_instr;
   logic [31:0]          ifid_pc_plus4;
   logic                 ifid_valid;
   logic [CNT_WIDTH-1:0] stall_cycles;
   logic [CNT_WIDTH-1:0] branch_flushes;
   logic [7:0]           stall_run;
   logic [7:0]           stall_run_next;
   logic                 watchdog;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // Only RUN/STALL cycles act on the hazard controls; BOOT is a dead cycle.
   always_comb begin
      state_next = state;
      active     = 1'b0;
      case (state)
         BOOT: begin
            state_next = RUN;
         end
         RUN, STALL: begin
            active     = 1'b1;
            state_next = bus.PCWriteEnable ? RUN : STALL;
         end
         default: begin
            state_next = BOOT;
         end
      endcase
      stall = active && !bus.PCWriteEnable;
      flush = active && bus.PCWriteEnable && bus.Branch;
   end

   assign pc_plus4       = pc + 32'd4;
   assign stall_run_next = (stall_run == 8'hFF) ? 8'hFF : stall_run + 8'd1;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         pc             <= RESET_PC;
         ifid_instr     <= '0;
         ifid_pc_plus4  <= '0;
         ifid_valid     <= 1'b0;
         stall_cycles   <= '0;
         branch_flushes <= '0;
         stall_run      <= '0;
         watchdog       <= 1'b0;
      end else begin
         if (flush) begin
            ifid_instr    <= '0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
         end else if (active && bus.IFIDWriteEnable) begin
            ifid_instr    <= bus.IMemData;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= 1'b1;
         end

         if (active && bus.PCWriteEnable) begin
            pc <= bus.Branch ? {bus.BranchTarget[31:2], 2'b00} : pc_plus4;
         end

         if (flush && (branch_flushes != CNT_MAX)) begin
            branch_flushes <= branch_flushes + CNT_WIDTH'(1);
         end

         // Watchdog keys off the post-increment run length, so it fires on the edge
         // that closes the STALL_LIMIT-th consecutive stall cycle.
         if (stall) begin
            stall_run <= stall_run_next;
            if (stall_cycles != CNT_MAX) begin
               stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            end
            if (stall_run_next == LIMIT) begin
               watchdog <= 1'b1;
            end
         end else if (active) begin
            stall_run <= '0;
         end
      end
   end

   assign bus.PC              = pc;
   assign bus.IFIDInstruction = ifid_instr;
   assign bus.IFIDPCPlus4     = ifid_pc_plus4;
   assign bus.IFIDValid       = ifid_valid;
   assign bus.StallCycles     = stall_cycles;
   assign bus.BranchFlushes   = branch_flushes;
   assign bus.StallWatchdog   = watchdog;
endmodule
`default_nettype wire

// File: doc/fetch_stage_ctrl.md
# fetch_stage_ctrl

Instruction-fetch stage controller for the five-stage MIPS pipeline. It owns the program counter and the IF/ID pipeline register, and it consumes the stall and redirect controls produced by hazard detection: PCWriteEnable, IFIDWriteEnable and Branch. Alongside fetch it keeps saturating stall and flush statistics and raises a sticky watchdog flag when the pipeline stays stalled too long.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- STALL_LIMIT, 8, consecutive stall cycles that trip the watchdog (range 1..255)
- CNT_WIDTH, 16, width of the statistics counters

Ports:
- Clock  in  1  sole clock; all state updates on the rising edge
- Reset  in  1  synchronous, active-high
- PCWriteEnable  in  1  1 = PC may advance or redirect this cycle
- IFIDWriteEnable  in  1  1 = IF/ID may load the fetched instruction this cycle
- Branch  in  1  taken branch/jump resolved in ID this cycle
- BranchTarget  in  32  redirect address, valid when Branch=1
- IMemData  in  32  instruction at address PC (combinational memory read)
- PC  out  32  current fetch address to instruction memory
- IFIDInstruction  out  32  IF/ID instruction
- IFIDPCPlus4  out  32  IF/ID PC+4
- IFIDValid  out  1  1 = IF/ID holds a real fetched instruction
- StallCycles  out  CNT_WIDTH  total cycles with PCWriteEnable=0, saturating
- BranchFlushes  out  CNT_WIDTH  total taken-branch flushes, saturating
- StallWatchdog  out  1  sticky; set when the consecutive-stall count reaches STALL_LIMIT

## Operation
- States: BOOT, RUN, STALL. Reset forces BOOT.
- BOOT lasts exactly one cycle. All inputs are ignored, outputs hold their reset values, and nothing counts. Next state is RUN.
- RUN/STALL: next state is STALL if PCWriteEnable=0 this cycle, otherwise RUN.
- PC update, in priority order:
  - PCWriteEnable=1 and Branch=1: PC <= {BranchTarget[31:2], 2'b00}.
  - PCWriteEnable=1: PC <= PC + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
  - Otherwise PC holds.
- IF/ID update, in priority order:
  - PCWriteEnable=1 and Branch=1 (flush): IFIDInstruction <= 0 (NOP), IFIDPCPlus4 <= 0, IFIDValid <= 0.
  - IFIDWriteEnable=1: IFIDInstruction <= IMemData, IFIDPCPlus4 <= PC + 4, IFIDValid <= 1.
  - Otherwise all IF/ID outputs hold.
- When PCWriteEnable=0, Branch is ignored: no redirect, no flush, no count. The branch is re-evaluated by ID once the stall releases.
- PCWriteEnable and IFIDWriteEnable are honoured independently when they differ. With PCWriteEnable=0 and IFIDWriteEnable=1, IF/ID reloads the instruction at the held PC.
- StallCycles increments by 1 in every RUN/STALL cycle with PCWriteEnable=0 and sticks at all-ones.
- BranchFlushes increments by 1 on every flush and sticks at all-ones.
- Watchdog:
  - An internal 8-bit consecutive-stall counter increments on each stall cycle and clears on any PCWriteEnable=1 cycle. It saturates at 255.
  - When the count after a stall cycle equals STALL_LIMIT, StallWatchdog <= 1. It stays 1 until Reset.
  - Fetch behaviour is unaffected by the watchdog.
- Reset values: PC=RESET_PC, IFIDInstruction=0, IFIDPCPlus4=0, IFIDValid=0, StallCycles=0, BranchFlushes=0, StallWatchdog=0, consecutive-stall count=0, state=BOOT.
- Reset asserted mid-stall or mid-redirect wins unconditionally. It discards the pending redirect and counts, and a BOOT cycle follows release.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- IMemData is sampled in the same cycle that PC presents its address.
- Reset released before edge k: BOOT occupies cycle k. The first fetch of RESET_PC is captured at the end of cycle k+1, so IFIDValid=1 from cycle k+2.
- Branch accepted in cycle n: PC=target and IF/ID=bubble in cycle n+1; the target instruction is in IF/ID in cycle n+2. The branch penalty is one bubble.
- A stall in cycle n holds PC and IF/ID through cycle n+1. Release in cycle m resumes advance at the m+1 edge, with no lost or duplicated instruction when both enables toggle together.
- The watchdog asserts on the edge ending the STALL_LIMIT-th consecutive stall cycle.

## Test plan
- Reset with RESET_PC=32'h0040_0000, both enables held 1, IMemData=PC ^ 32'hA5A5_A5A5 -> BOOT for one cycle. Then PC steps 0x400000, 0x400004, 0x400008, and IF/ID shows each matching word with IFIDPCPlus4=PC+4, one cycle later.
- Branch=1, BranchTarget=32'h0000_1003 with PCWriteEnable=1 at PC=0x100 -> next cycle PC=0x1000, IFIDInstruction=0, IFIDValid=0, BranchFlushes=1. The cycle after, IF/ID holds the word at 0x1000.
- Both enables 0 for 3 cycles with Branch=1 throughout -> PC and IF/ID frozen, no redirect, StallCycles=3, BranchFlushes unchanged. After release, PC+4 resumes and no instruction is dropped or duplicated.
- STALL_LIMIT=8: stall 7 cycles, release 1, stall 8 -> StallWatchdog stays 0 after the first run and rises on the 8th stall of the second run. It stays 1 after release and clears only on Reset.
- PC=32'hFFFF_FFFC with enables 1 -> next PC=0. With CNT_WIDTH=4 and 20 stall cycles -> StallCycles=4'hF.
- Reset asserted while stalled with Branch pending -> next cycle all outputs equal their reset values. A BOOT cycle follows, with no redirect to BranchTarget.
